// File: rtl/ccu_pkg.sv
// ccu_pkg: shared constants and elaboration helpers for the ccu_slice_array
// carry-chain datapath.
//   OP_*      : operation encodings presented on the OP bus field.
//   DIR_*     : count direction encodings presented on the DIR field.
//   ccu_mode_ok : returns 1 when the parameter set is legal (even WIDTH >= 2,
//                 0 < CNT_MAX <= 2**WIDTH-1).
package ccu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CNT = 2'b11;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // cnt_max_zero / cnt_max_over are precomputed by the caller because the
    // bound is WIDTH+1 bits wide and cannot be passed generically here.
    function automatic bit ccu_mode_ok(input int unsigned width,
                                       input bit          cnt_max_zero,
                                       input bit          cnt_max_over);
        return (width >= 32'd2) && ((width % 32'd2) == 32'd0) &&
               !cnt_max_zero && !cnt_max_over;
    endfunction

endpackage

// File: rtl/ccu_slice_array_if.sv
// ccu_slice_array_if: control, operand and result signals of one
// ccu_slice_array. Clock and reset are kept as plain ports on the block.
//   master : drives CE/SCLR/LOAD/OP/DIR/A/B/DI/FCI, observes results.
//   slave  : the datapath; consumes controls, drives F/FCO/Q/QCO/TC/OVF.
interface ccu_slice_array_if #(
    parameter int WIDTH = 8
);
    logic             CE;
    logic             SCLR;
    logic             LOAD;
    logic [1:0]       OP;
    logic             DIR;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] DI;
    logic             FCI;
    logic [WIDTH-1:0] F;
    logic             FCO;
    logic [WIDTH-1:0] Q;
    logic             QCO;
    logic             TC;
    logic             OVF;

    modport master (
        output CE, SCLR, LOAD, OP, DIR, A, B, DI, FCI,
        input  F, FCO, Q, QCO, TC, OVF
    );

    modport slave (
        input  CE, SCLR, LOAD, OP, DIR, A, B, DI, FCI,
        output F, FCO, Q, QCO, TC, OVF
    );
endinterface

// File: rtl/ccu2_pair.sv
// ccu2_pair: two-bit propagate/generate carry cell.
//   a_i, b_i : 2-bit addends
//   ci_i     : carry into bit 0
//   s_o      : 2-bit sum
//   co_o     : carry out of bit 1
module ccu2_pair (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic       ci_i,
    output logic [1:0] s_o,
    output logic       co_o
);
    logic [1:0] p_s;
    logic [1:0] g_s;
    logic       c1_s;

    assign p_s  = a_i ^ b_i;
    assign g_s  = a_i & b_i;
    assign c1_s = g_s[0] | (p_s[0] & ci_i);
    assign co_o = g_s[1] | (p_s[1] & c1_s);
    assign s_o  = {p_s[1] ^ c1_s, p_s[0] ^ ci_i};
endmodule

// File: rtl/ccu_slice_array.sv
// ccu_slice_array: WIDTH-bit carry-chain datapath with output register bank.
//   CLK : rising-edge clock
//   LSR : asynchronous active-high reset (Q=RESET_VAL, flags cleared)
//   bus : ccu_slice_array_if.slave
//         inputs  CE, SCLR, LOAD, OP, DIR, A, B, DI, FCI
//         outputs F/FCO (combinational chain), Q/QCO/TC/OVF (registered)
// OP: ADD A+B+cin, SUB A+~B+cin, ACC Q+A+cin, CNT Q+/-1 bounded by CNT_MAX.
module ccu_slice_array
    import ccu_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SCLR_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH:0]   CNT_MAX   = {1'b0, {WIDTH{1'b1}}},
    parameter bit               SAT_MODE  = 1'b0,
    parameter bit               FCI_EN    = 1'b1
) (
    input  logic              CLK,
    input  logic              LSR,
    ccu_slice_array_if.slave  bus
);
    localparam int               NPAIR   = WIDTH / 2;
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BOUND_W = CNT_MAX[WIDTH-1:0];
    localparam bit MODE_OK = ccu_mode_ok(WIDTH, CNT_MAX == {(WIDTH+1){1'b0}},
                                         CNT_MAX[WIDTH]);

    if (!MODE_OK) begin : g_bad_mode
        $error("ccu_slice_array: WIDTH must be even and >= 2, and 0 < CNT_MAX <= 2**WIDTH-1");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             qco_q, qco_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] opb_s;
    logic             cin_s;
    logic [WIDTH-1:0] f_s;
    logic             fco_s;

    // Chain operand select. CNT down adds all-ones with cin=0, so FCO=1
    // means "no borrow" exactly as for SUB.
    always_comb begin
        opa_s = bus.A;
        opb_s = bus.B;
        cin_s = FCI_EN ? bus.FCI : 1'b0;
        case (bus.OP)
            OP_ADD: begin
                opa_s = bus.A;
                opb_s = bus.B;
            end
            OP_SUB: begin
                opb_s = ~bus.B;
                cin_s = FCI_EN ? bus.FCI : 1'b1;
            end
            OP_ACC: begin
                opa_s = q_q;
                opb_s = bus.A;
            end
            OP_CNT: begin
                opa_s = q_q;
                opb_s = (bus.DIR == DIR_UP) ? ZERO_W : ONES_W;
                cin_s = (bus.DIR == DIR_UP) ? 1'b1 : 1'b0;
            end
            default: begin
                opa_s = bus.A;
                opb_s = bus.B;
            end
        endcase
    end

    // Ripple of two-bit cells; each cell keeps its own carry net so the
    // chain is a set of distinct signals rather than one self-feeding vector.
    for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
        logic ci_s;
        logic co_s;
        if (gi == 0) begin : g_first
            assign ci_s = cin_s;
        end else begin : g_next
            assign ci_s = g_pair[gi-1].co_s;
        end
        ccu2_pair u_pair (
            .a_i  (opa_s[2*gi+1 -: 2]),
            .b_i  (opb_s[2*gi+1 -: 2]),
            .ci_i (ci_s),
            .s_o  (f_s[2*gi+1 -: 2]),
            .co_o (co_s)
        );
    end

    assign fco_s = g_pair[NPAIR-1].co_s;

    // Next-state for Q and flags: SCLR > LOAD > CE > hold; TC is a pulse.
    always_comb begin
        q_d   = q_q;
        qco_d = qco_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (bus.SCLR) begin
            q_d   = SCLR_VAL;
            qco_d = 1'b0;
            ovf_d = 1'b0;
        end else if (bus.LOAD) begin
            q_d   = bus.DI;
            qco_d = 1'b0;
        end else if (bus.CE) begin
            if (bus.OP == OP_CNT) begin
                qco_d = 1'b0;
                if (bus.DIR == DIR_UP) begin
                    // At or beyond the bound: wrap to 0; only an exact hit
                    // of the bound may saturate.
                    if ({1'b0, q_q} >= CNT_MAX) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        q_d   = (SAT_MODE && ({1'b0, q_q} == CNT_MAX)) ? BOUND_W : ZERO_W;
                    end else begin
                        q_d = f_s;
                    end
                end else begin
                    if (q_q == ZERO_W) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        q_d   = SAT_MODE ? ZERO_W : BOUND_W;
                    end else begin
                        q_d = f_s;
                    end
                end
            end else begin
                q_d   = f_s;
                qco_d = fco_s;
                if (bus.OP == OP_SUB) begin
                    ovf_d = ovf_q | ~fco_s;
                end else begin
                    ovf_d = ovf_q | fco_s;
                end
            end
        end else begin
            q_d = q_q;
        end
    end

    // Output register bank with asynchronous reset.
    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            q_q   <= RESET_VAL;
            qco_q <= 1'b0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            qco_q <= qco_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.F   = f_s;
    assign bus.FCO = fco_s;
    assign bus.Q   = q_q;
    assign bus.QCO = qco_q;
    assign bus.TC  = tc_q;
    assign bus.OVF = ovf_q;

endmodule

// File: doc/ccu_slice_array.md
Name: ccu_slice_array

Overview:
- Parametrised successor to the two-bit carry slice: a WIDTH-bit carry-chain datapath with an integrated output register bank.
- Adds add, subtract, accumulate and up/down count operations, plus registered carry, terminal-count and sticky-overflow flags.
- Sits in the ecp5u primitive layer; fabric wrappers use it for counters, accumulators and comparators without hand-chaining two-bit slices.

Parameters:
- WIDTH, 8: datapath width in bits; must be even and ≥ 2.
- RESET_VAL, 0: Q value forced by LSR.
- SCLR_VAL, 0: Q value forced by a synchronous clear.
- CNT_MAX, 2**WIDTH-1: count-mode upper bound, with 0 < CNT_MAX ≤ 2**WIDTH-1.
- SAT_MODE, 0: selects the count-mode boundary behaviour. 0 wraps; 1 saturates at the bound.
- FCI_EN, 1: 1 routes FCI into bit 0 carry-in. 0 ties the carry-in to the operation default.

Ports:
- CLK  input  1  clock; rising edge active.
- LSR  input  1  asynchronous, active-high reset.
- CE  input  1  clock enable for Q and the flags.
- SCLR  input  1  synchronous clear; priority over LOAD and CE.
- LOAD  input  1  synchronous load of DI into Q; priority over CE.
- OP  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CNT.
- DIR  input  1  CNT direction: 1 up, 0 down.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- DI  input  WIDTH  load data.
- FCI  input  1  carry-in from the previous array.
- F  output  WIDTH  combinational chain result.
- FCO  output  1  combinational chain carry-out.
- Q  output  WIDTH  registered result.
- QCO  output  1  registered carry/borrow.
- TC  output  1  registered terminal-count pulse.
- OVF  output  1  sticky overflow.

Behaviour:
- Chain function, per OP:
  - ADD: F = A+B+cin, with cin = FCI_EN ? FCI : 0.
  - SUB: F = A+~B+cin, with cin = FCI_EN ? FCI : 1.
  - ACC: F = Q+A+cin, with cin = FCI_EN ? FCI : 0.
  - CNT: F = Q+1 when DIR=1, Q-1 when DIR=0; FCI is ignored.
- FCO is the carry out of the MSB. SUB FCO=1 means no borrow.
- Everything is computed at width WIDTH+1; F takes the low WIDTH bits.
- Asynchronous reset: LSR=1 immediately sets Q=RESET_VAL and QCO=TC=OVF=0, held while LSR is asserted. Deassertion takes effect at the next edge.
- Per-edge priority at a rising CLK edge: SCLR > LOAD > CE > hold.
- SCLR: Q=SCLR_VAL, QCO=0, TC=0, OVF=0.
- LOAD: Q=DI, QCO=0, TC=0; OVF unchanged.
- CE=1, non-CNT OPs: Q=F, QCO=FCO, TC=0.
- CE=1, CNT up:
  - Q==CNT_MAX: Q becomes 0 (wrap) or holds CNT_MAX (SAT), and TC=1.
  - Otherwise Q=Q+1 and TC=0.
- CE=1, CNT down:
  - Q==0: Q becomes CNT_MAX (wrap) or holds 0 (SAT), and TC=1.
  - Otherwise Q=Q-1 and TC=0.
- CNT values of Q above CNT_MAX (reachable only by LOAD): up → 0 with TC=1; down → Q-1 normally.
- CE=0 with no SCLR/LOAD: Q, QCO and OVF hold; TC clears to 0, so TC is a one-cycle pulse.
- Latency: Q, QCO and TC reflect their inputs one cycle after the sampling edge. F and FCO have zero latency.
- OVF is set at a CE edge on:
  - ADD/ACC carry-out = 1;
  - SUB borrow (FCO=0);
  - CNT wrap.
  OVF clears only on LSR or SCLR. A saturating CNT boundary also sets OVF.
- Reset mid-operation: an LSR pulse between edges clears state immediately. The next edge after release resumes from RESET_VAL.
- Simultaneous SCLR and LOAD: SCLR wins and DI is discarded.

Decomposition:
- Shared package ccu_pkg holds:
  - OP encoding constants OP_ADD, OP_SUB, OP_ACC, OP_CNT;
  - the DIR_UP/DIR_DN constants;
  - the mode-check function that flags an odd WIDTH or CNT_MAX out of range at elaboration.
- One natural sub-module, ccu2_pair: a two-bit propagate/generate carry cell with carry-in and carry-out, instantiated WIDTH/2 times in a generate loop.
- The register bank and flag logic stay in the top module.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'h5A, assert LSR mid-cycle → Q=8'h5A immediately, QCO=TC=OVF=0. Release, CE=0 → Q holds 8'h5A.
- ADD overflow: OP=00, A=8'hF0, B=8'h20, FCI=0, CE=1 → F=8'h10 and FCO=1 the same cycle. At the next edge Q=8'h10, QCO=1, OVF=1, sticky through 3 further idle cycles.
- SUB borrow: OP=01, FCI_EN=0, A=8'h03, B=8'h05 → F=8'hFE, FCO=0. After the edge Q=8'hFE and OVF=1.
- Count wrap/saturate with CNT_MAX=9, OP=11, DIR=1, CE=1 from Q=0:
  - SAT_MODE=0: Q steps 1..9 then 0; TC=1 only in the cycle after 9→0.
  - SAT_MODE=1: Q sticks at 9 with TC=1 on each CE edge while at the bound.
  - DIR=0 from 0: Q=9 with SAT_MODE=0, or Q=0 with SAT_MODE=1.
- Priority: SCLR=1, LOAD=1, CE=1, DI=8'h77, SCLR_VAL=8'h00 → Q=8'h00 and OVF cleared. Next cycle SCLR=0, LOAD=1 → Q=8'h77, OVF unchanged.
- Accumulate: OP=10, A=8'h11, CE=1 for 4 edges from Q=0 → Q = 11, 22, 33, 44 (hex), QCO=0, TC=0 throughout.
